// File: rtl/mux8_rr_arbiter_pkg.sv
// Shared types and sizes for the 8-way round-robin mux arbiter.
package mux8_arb_pkg;

    localparam int ARB_N     = 8;
    localparam int ARB_IDX_W = 3;

    typedef enum logic {
        IDLE,
        OWNED
    } arb_state_e;

    function automatic logic [ARB_N-1:0] onehot(
        input logic [ARB_IDX_W-1:0] idx
    );
        return ARB_N'(1) << idx;
    endfunction

endpackage

// File: rtl/mux8_rr_arbiter_if.sv
// Request/grant bundle between requesting units (master)
// and the arbiter (slave).
interface mux8_rr_arbiter_if;
    import mux8_arb_pkg::*;

    logic [ARB_N-1:0]     req;
    logic [ARB_N-1:0]     done;
    logic [ARB_N-1:0]     grant;
    logic [ARB_IDX_W-1:0] sel;
    logic                 busy;
    logic                 timeout;

    modport master (
        output req, done,
        input  grant, sel, busy, timeout
    );

    modport slave (
        input  req, done,
        output grant, sel, busy, timeout
    );

endinterface

// File: rtl/mux8_rr_arbiter_rr_pick8.sv
// Rotate-priority picker: first set bit of req at or after
// start, wrapping 7 -> 0.
module rr_pick8
    import mux8_arb_pkg::*;
(
    input  logic [ARB_N-1:0]     req,
    input  logic [ARB_IDX_W-1:0] start,
    output logic                 found,
    output logic [ARB_IDX_W-1:0] idx
);

    always_comb begin
        logic [ARB_IDX_W-1:0] j;
        found = 1'b0;
        idx   = start;
        j     = start;
        for (int i = 0; i < ARB_N; i++) begin
            j = start + ARB_IDX_W'(i);
            if (!found && req[j]) begin
                found = 1'b1;
                idx   = j;
            end
        end
    end

endmodule

// File: rtl/mux8_rr_arbiter.sv
// Round-robin owner arbiter driving the shared 8:1 mux select.
// Define MUX8_ARB_TIMEOUT_EN to enable forced release after MAX_HOLD cycles.
module mux8_rr_arbiter
    import mux8_arb_pkg::*;
#(
    parameter int MAX_HOLD = 15
) (
    input  logic               clk,
    input  logic               reset,
    mux8_rr_arbiter_if.slave   bus
);

    if (MAX_HOLD < 1) begin : g_bad_hold
        $error("MAX_HOLD must be at least 1");
    end

    arb_state_e           state, state_n;
    logic [ARB_N-1:0]     grant_q, grant_n;
    logic [ARB_IDX_W-1:0] sel_q, sel_n;
    logic [ARB_IDX_W-1:0] last_q, last_n;
    logic [ARB_IDX_W-1:0] start;
    logic [ARB_N-1:0]     pick_req;
    logic                 pick_found;
    logic [ARB_IDX_W-1:0] pick_idx;
    logic                 owned;
    logic                 norm_rel;
    logic                 force_rel;
    logic                 release_now;
    logic                 load;

    assign owned    = (state == OWNED);
    assign norm_rel = owned &&
                      (bus.done[sel_q] || !bus.req[sel_q]);
    assign release_now = norm_rel || force_rel;
    // The releasing owner is masked so it drops to lowest priority.
    assign pick_req = owned ? (bus.req & ~grant_q) : bus.req;
    assign start    = last_q + ARB_IDX_W'(1);

    rr_pick8 u_pick (
        .req   (pick_req),
        .start (start),
        .found (pick_found),
        .idx   (pick_idx)
    );

`ifdef MUX8_ARB_TIMEOUT_EN
    localparam int CW = $clog2(MAX_HOLD + 1);

    logic [CW-1:0] cnt_q, cnt_n;
    logic          timeout_q;

    // Fires on the last permitted owned cycle.
    assign force_rel = owned && !norm_rel &&
                       (cnt_q == CW'(MAX_HOLD - 1));

    always_comb begin
        cnt_n = cnt_q;
        if (load) begin
            cnt_n = '0;
        end else if (owned && !release_now &&
                     cnt_q != CW'(MAX_HOLD)) begin
            cnt_n = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_n;
            timeout_q <= force_rel;
        end
    end
`else
    assign force_rel = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            grant_q <= '0;
            sel_q   <= '0;
            last_q  <= ARB_IDX_W'(ARB_N - 1);
        end else begin
            state   <= state_n;
            grant_q <= grant_n;
            sel_q   <= sel_n;
            last_q  <= last_n;
        end
    end

    always_comb begin
        state_n = state;
        grant_n = grant_q;
        sel_n   = sel_q;
        last_n  = last_q;
        load    = 1'b0;
        unique case (state)
            IDLE: begin
                if (pick_found) load = 1'b1;
            end
            OWNED: begin
                if (release_now) begin
                    if (pick_found) begin
                        load = 1'b1;
                    end else begin
                        state_n = IDLE;
                        grant_n = '0;
                    end
                end
            end
        endcase
        if (load) begin
            state_n = OWNED;
            grant_n = onehot(pick_idx);
            sel_n   = pick_idx;
            last_n  = pick_idx;
        end
    end

    always_comb begin
        bus.grant = grant_q;
        bus.sel   = sel_q;
        bus.busy  = |grant_q;
`ifdef MUX8_ARB_TIMEOUT_EN
        bus.timeout = timeout_q;
`else
        bus.timeout = 1'b0;
`endif
    end

endmodule

// File: doc/mux8_rr_arbiter.md
# mux8_rr_arbiter

Round-robin arbiter that shares one 8-input mux path (built from `mux_8to1` slices) among 8 requesters. It registers a one-hot grant and drives the matching 3-bit select to the mux `s` inputs. Ownership is held until the owner signals done or drops its request. It sits between the requesting datapath units and the shared mux.

## Interface
- `MAX_HOLD`, default 15: maximum consecutive owned cycles before forced release. Must be at least 1. Used only when `MUX8_ARB_TIMEOUT_EN` is defined.
- `clk` input, 1: clock. All state updates on the rising edge.
- `reset` input, 1: synchronous, active-high reset.
- `req` input, 8: request per requester; bit i corresponds to mux input i.
- `done` input, 8: release strobe per requester. Only the current owner's bit is honoured.
- `grant` output, 8: registered, one-hot or zero.
- `sel` output, 3: registered binary index of the owner, wired to mux `s`. Holds its last value when idle.
- `busy` output, 1: high when `grant` is non-zero.
- `timeout` output, 1: one-cycle pulse on a forced release. Tied to 0 when the macro is absent.

## Operation
- States:
  - IDLE: `grant` = 0.
  - OWNED: `grant` = one-hot(owner).
- Pointer `last` (3 bits) records the most recent owner. The search for the next owner starts at `(last+1) mod 8` and wraps through index 7 back to 0. The first requesting index found wins.
- IDLE → OWNED: on any set bit in `req`. The winner is loaded into `grant` and `sel`, and `last` ← winner.
- OWNED, release condition: `done[owner]`=1 or `req[owner]`=0. Both asserted together count as a single release.
- OWNED, release when other requests are pending: hand off directly to the next winner on the following edge, with no idle bubble. The search excludes the releasing owner.
- OWNED, release when no other request is pending: go to IDLE. `grant` → 0, `sel` retains its value.
- After release, the released owner has the lowest priority. It wins again only if no other bit of `req` is set.
- `done` bits of non-owners are ignored in every state.
- Changes to `req` bits of non-owners while OWNED do not affect the current owner.
- Reset values: `grant`=0, `sel`=0, `busy`=0, `timeout`=0, `last`=7 (so the first search starts at index 0), hold counter=0, state=IDLE.
- A reset asserted mid-ownership takes priority over all other inputs and returns every output to its reset value on the next edge.

## Timing
- Request to grant: `req` sampled high at edge t in IDLE → `grant`/`sel` valid after edge t; one cycle of latency.
- Release to next grant: release sampled at edge t → new `grant` valid after edge t (back-to-back handoff).
- `sel` and `grant` change on the same edge and are never inconsistent.
- `busy` is combinational from registered `grant`, giving zero added latency.
- Hold counter: cleared on every grant or handoff, incremented each OWNED cycle without release. Width is `$clog2(MAX_HOLD+1)`, and it saturates and never wraps.

## Configuration
- `MUX8_ARB_TIMEOUT_EN` defined:
  - When the hold counter reaches `MAX_HOLD` with no release, a forced release occurs, handled identically to a normal release including handoff.
  - `timeout` pulses high for the cycle following the forced-release edge.
  - A normal release in the same cycle takes precedence, and `timeout` stays 0.
- `MUX8_ARB_TIMEOUT_EN` undefined:
  - No counter logic is built.
  - `timeout` is constant 0.
  - The owner may hold indefinitely.

## Structure
- Shared package `mux8_arb_pkg` holds:
  - `ARB_N` = 8 and `ARB_IDX_W` = 3.
  - The state enum: IDLE, OWNED.
- Sub-module `rr_pick8`: combinational rotate-priority picker.
  - Inputs: 8-bit request vector, 3-bit start index.
  - Outputs: `found`, 3-bit index.
  - Instantiated once.
- The `mux_8to1` slices are not instantiated inside this block. `sel` is exported to them.

## Test plan
- Reset, then `req`=8'h01 → one cycle later `grant`=8'h01, `sel`=0, `busy`=1. Then `done`=8'h01, `req`=0 → `grant`=0, `sel`=0.
- `req`=8'hFF held; each owner pulses `done` after 2 cycles → grant order 0,1,2,…,7,0, with no idle cycle between owners.
- Owner 3, `req`=8'h88, `done[3]` → next cycle `grant`=8'h80, `sel`=7. Then `done[7]` with `req`=8'h08 → `grant`=8'h08, `sel`=3, confirming wrap-around.
- Owner 2, `done`=8'h20 pulsed → `grant` stays 8'h04, `sel`=2.
- Macro defined, `MAX_HOLD`=4, `req`=8'h03 held with no `done` → owner 0 released after 4 cycles, `timeout` pulses once, `grant`=8'h02.
- Owner 6 active, `reset` pulsed → next edge `grant`=0, `sel`=0, `busy`=0. With `req`=8'hC0 after reset → owner 6 is granted first, because the search starts at index 0 and finds 6 before 7.
